instmem_arbiter: RTL
====================

Name: instmem_arbiter

Overview:
- Two-requester read arbiter and sequencer for the 512 x 32-bit synchronous instruction ROM. The ROM has a 1-cycle registered read and no enable.
- Shares the ROM between the fetch unit (m0) and the debug/loader read port (m1). Uses valid/ready request and response handshakes.
- Pipelined: one in-flight stage and one response stage, sustaining 1 read/cycle.
- Holds the ROM address stable under response backpressure so read data is never lost.

Parameters:
- ADDR_W, 9, ROM word-address width.
- DATA_W, 32, ROM word width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- m0_req_valid  in  1  fetch read request
- m0_req_addr  in  ADDR_W  fetch word address
- m0_req_ready  out  1  fetch request accepted this cycle
- m0_rsp_valid  out  1  fetch read data valid
- m0_rsp_data  out  DATA_W  fetch read data
- m0_rsp_ready  in  1  fetch consumes response
- m1_req_valid / m1_req_addr / m1_req_ready / m1_rsp_valid / m1_rsp_data / m1_rsp_ready  same as m0, for the debug/loader port
- mem_addr  out  ADDR_W  to ROM addr
- mem_dout  in  DATA_W  from ROM dout

Behaviour:
- Reset (reset==0 at clk edge):
  - S1 and S2 invalid; rr pointer = m0 (m0 preferred); mem_addr_q = 0.
  - mX_rsp_valid = 0; mX_rsp_data = 0; mX_req_ready = 0 while reset==0.
- S1 (in flight): valid, owner, addr.
- S2 (response): valid, owner, data.
- Drain: S2 drains when S2.valid and the owner's rsp_ready==1.
- Advance: s1_adv = !S1.valid | !S2.valid | drain.
- Accept: accept = s1_adv & (m0_req_valid | m1_req_valid).
  - Winner's req_ready = accept; loser's req_ready = 0.
- Arbitration:
  - FIXED_PRIO=1: m0 wins.
  - Otherwise round-robin. On a tie the winner is the rr pointer; after a grant the pointer moves to the other port. A single requester always wins.
- mem_addr (combinational):
  - accept: the winner's addr.
  - otherwise: S1.valid ? S1.addr : mem_addr_q (last issued).
  - Holding the address keeps mem_dout stable while S1 is stalled.
- Edge after accept (E0): S1 <= {1, winner, addr}. The ROM samples mem_addr at E0; mem_dout is valid in the following cycle.
- Next edge (E1), if s1_adv: S2 <= {1, S1.owner, mem_dout}; S1 <= the new accept or invalid.
- Latency: rsp_valid is high 2 edges after the accepting edge. Throughput is 1/cycle when rsp_ready is held high.
- If S2 holds and is not drained, S2 stays frozen. S1 stays frozen with mem_addr = S1.addr. No new accept occurs.
- mX_rsp_valid = S2.valid & (S2.owner==X). mX_rsp_data = S2.data (0 for the non-owner).
- Responses return in grant order; each port sees its own requests in order.
- Simultaneous drain and S1 advance in the same cycle is legal; no bubble.
- Reset mid-operation discards S1 and S2 silently; no response is produced.
- The ROM's own reset is handled outside this block.

Optional Feature:
- Macro INSTMEM_ARB_PERF_EN.
- Defined: adds outputs perf_m0_grants, perf_m1_grants, perf_stalls, each 16 bits, saturating at 0xFFFF, cleared by reset.
  - Grant counters increment on accept for that port.
  - perf_stalls increments every cycle where some req_valid==1 and s1_adv==0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- instmem_pkg: ADDR_W and DATA_W defaults, owner encoding (OWN_M0=0, OWN_M1=1), perf counter width 16.
- Sub-module rr_arb2: 2-way round-robin/fixed arbiter with a pointer register. It contains all arbitration logic.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both req_valid=1 -> req_ready=0, rsp_valid=0, no grant. First accept after release goes to m0.
- Single read: m0 addr 0x005, rsp_ready=1, rom[5]=0x2402000A -> m0_rsp_valid=1 exactly 2 edges after accept, data 0x2402000A; m1_rsp_valid stays 0.
- Contention: both valid continuously, m0 addrs 0,1,2 and m1 addrs 0x100,0x101,0x102, rsp_ready=1 -> grants m0,m1,m0,m1,m0,m1 on consecutive cycles; 6 responses in grant order, one per cycle. With FIXED_PRIO=1, m1 gets no grant while m0 is valid.
- Backpressure: m1 reads 0x010 and m0 reads 0x011 back-to-back; m1_rsp_ready=0 for 4 cycles -> m1_rsp_data=rom[0x10] stable, mem_addr held at 0x011, all req_ready=0. After release, m1 then m0 receive correct data with no loss or duplication.
- Reset mid-flight: S1 and S2 both valid, then reset=0 for 1 cycle -> next cycle rsp_valid=0 on both ports, pointer back at m0, no stale response afterwards.
- Perf (INSTMEM_ARB_PERF_EN): the contention run plus a 4-cycle stall -> perf_m0_grants=3, perf_m1_grants=3, perf_stalls=4. Forcing 70000 grants -> saturates at 0xFFFF.

Source files
------------

// File: rtl/instmem_pkg.sv
// instmem_pkg: shared widths and owner encoding for the instruction ROM arbiter.
package instmem_pkg;
  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int PERF_W = 16;
  typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin or fixed-priority arbiter with a pointer register.
module rr_arb2
  import instmem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       accept,
  output owner_t     winner
);
  owner_t ptr;
  assign accept = adv & |req;
  assign winner = FIXED_PRIO ? (req[0] ? OWN_M0 : OWN_M1)
                : (&req ? ptr : (req[1] ? OWN_M1 : OWN_M0));
  // Pointer hands the next tie to the port that just lost.
  always_ff @(posedge clk)
    if (!reset) ptr <= OWN_M0;
    else if (accept) ptr <= owner_t'(~winner);
endmodule

// File: rtl/instmem_arbiter.sv
// instmem_arbiter: two-port pipelined read arbiter for the synchronous instruction ROM.
// Define INSTMEM_ARB_PERF_EN to add saturating grant/stall counters.
module instmem_arbiter
  import instmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_valid,
  input  logic [ADDR_W-1:0] m0_req_addr,
  output logic              m0_req_ready,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_data,
  input  logic              m0_rsp_ready,
  input  logic              m1_req_valid,
  input  logic [ADDR_W-1:0] m1_req_addr,
  output logic              m1_req_ready,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_data,
  input  logic              m1_rsp_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout
`ifdef INSTMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_m0_grants,
  output logic [PERF_W-1:0] perf_m1_grants,
  output logic [PERF_W-1:0] perf_stalls
`endif
);
  logic              s1_valid, s2_valid, drain, s1_adv, accept;
  owner_t            s1_owner, s2_owner, winner;
  logic [ADDR_W-1:0] s1_addr, mem_addr_q, req_addr;
  logic [DATA_W-1:0] s2_data;

  assign drain  = s2_valid & (s2_owner == OWN_M1 ? m1_rsp_ready : m0_rsp_ready);
  assign s1_adv = !s1_valid | !s2_valid | drain;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({m1_req_valid, m0_req_valid}),
    .adv    (s1_adv & reset),
    .accept (accept),
    .winner (winner)
  );

  assign req_addr     = winner == OWN_M1 ? m1_req_addr : m0_req_addr;
  assign m0_req_ready = accept & (winner == OWN_M0);
  assign m1_req_ready = accept & (winner == OWN_M1);
  // Re-present the stalled address so the ROM keeps driving the same word.
  assign mem_addr     = accept ? req_addr : (s1_valid ? s1_addr : mem_addr_q);
  assign m0_rsp_valid = s2_valid & (s2_owner == OWN_M0);
  assign m1_rsp_valid = s2_valid & (s2_owner == OWN_M1);
  assign m0_rsp_data  = m0_rsp_valid ? s2_data : '0;
  assign m1_rsp_data  = m1_rsp_valid ? s2_data : '0;

  always_ff @(posedge clk)
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_owner   <= OWN_M0;
      s1_addr    <= '0;
      s2_valid   <= 1'b0;
      s2_owner   <= OWN_M0;
      s2_data    <= '0;
      mem_addr_q <= '0;
    end else begin
      if (accept) mem_addr_q <= req_addr;
      if (s1_adv) begin
        s1_valid <= accept;
        s1_owner <= winner;
        s1_addr  <= req_addr;
      end
      if (!s2_valid | drain) begin
        s2_valid <= s1_valid;
        s2_owner <= s1_owner;
        s2_data  <= mem_dout;
      end
    end

`ifdef INSTMEM_ARB_PERF_EN
  logic stall;
  assign stall = (m0_req_valid | m1_req_valid) & !s1_adv;
  always_ff @(posedge clk)
    if (!reset) begin
      perf_m0_grants <= '0;
      perf_m1_grants <= '0;
      perf_stalls    <= '0;
    end else begin
      if (m0_req_ready && perf_m0_grants != '1) perf_m0_grants <= perf_m0_grants + 1'b1;
      if (m1_req_ready && perf_m1_grants != '1) perf_m1_grants <= perf_m1_grants + 1'b1;
      if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
    end
`endif
endmodule
